text_ram_scheduler: RTL
=======================

# text_ram_scheduler

Sequences every access to the single-port text RAM that holds the character/attribute grid. Three requesters share the port: the video renderer's fetch stream, the parser's single read/write accesses, and a built-in fill engine used for erase and scroll-clear bursts. The block sits between the VT100 parser, the renderer and the RAM macro. It enforces fixed priority, renderer > parser > fill. It also guarantees that parser accesses issued after a fill start observe the completed fill.

## Interface
- ADDR_W, 12, text RAM word address width
- DATA_W, 32, text RAM word width (character + attributes)
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- render_req  in  1  renderer wants a read this cycle; not held, no ack
- render_addr  in  ADDR_W  renderer read address
- render_valid  out  1  render_data valid (one cycle after accepted render_req)
- render_data  out  DATA_W  renderer read data
- parser_req  in  1  parser access request; held until parser_ack
- parser_we  in  1  1 = write, 0 = read; stable while parser_req high
- parser_addr  in  ADDR_W  parser address; stable while parser_req high
- parser_wdata  in  DATA_W  parser write data; stable while parser_req high
- parser_ack  out  1  one-cycle pulse: write done, or read data valid
- parser_rdata  out  DATA_W  parser read data, valid with parser_ack on reads
- fill_start  in  1  one-cycle pulse that starts a fill; ignored while fill_busy
- fill_base  in  ADDR_W  first fill address, sampled on fill_start
- fill_len  in  ADDR_W+1  number of words to write, sampled on fill_start
- fill_data  in  DATA_W  word written to every fill location, sampled on fill_start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse when the fill completes
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, one-cycle latency

## Operation
- Arbitration is evaluated each cycle T. The ram_* outputs are combinational from the arbitration result.
- Priority 1, render: if render_req=1, the block issues a read at render_addr. render_valid pulses at T+1 with render_data=ram_rdata. Render is never stalled.
- Priority 2, parser: granted when all of the following hold:
  - render_req=0
  - fill FSM is IDLE
  - parser_ack is not asserted in cycle T
  - no parser access is in flight
- On parser grant: write → ram_we=1 and parser_ack at T+1; read → parser_ack at T+1 with parser_rdata=ram_rdata.
- The one-cycle ack gap means a request still high during its ack cycle is never double-granted. Maximum parser rate is one access per 2 cycles.
- Priority 3, fill: the fill FSM has two states, IDLE and FILL.
  - IDLE→FILL on fill_start with fill_len≠0. This latches ptr=fill_base, remaining=fill_len, word=fill_data and raises fill_busy at T+1.
  - fill_start with fill_len=0 produces fill_done at T+1, performs no writes, and leaves fill_busy low.
  - In FILL, each cycle with render_req=0 writes word to ptr, increments ptr modulo 2^ADDR_W (wraps), and decrements remaining. Render cycles pause the fill without losing position.
  - When the write with remaining=1 is issued, the FSM returns to IDLE. fill_busy drops and fill_done pulses in the following cycle.
  - fill_start while fill_busy=1 is ignored; no state change.
- Ordering: a parser request pending during a fill waits until the fill completes, then is granted normally.
- Parser request and fill_start in the same IDLE cycle: the parser wins the RAM in that cycle. fill_start is still latched, and the fill begins next cycle.
- When no requester is active: ram_en=0, ram_we=0.

## Timing
- Reset (synchronous, rst=1 at a clk edge): FSM→IDLE; any in-flight fill is aborted without fill_done; the in-flight parser access is dropped without ack.
- Reset values of outputs: render_valid=0, parser_ack=0, fill_busy=0, fill_done=0, ram_en=0, ram_we=0. Data outputs (render_data, parser_rdata, ram_addr, ram_wdata) reset to 0.
- Render latency: exactly 1 cycle, accept to render_valid.
- Parser latency: 1 cycle from grant; unbounded while render/fill hold the port.
- Fill duration: fill_len + (render cycles during fill) cycles; fill_done one cycle after the last write.
- Address arithmetic: ptr wraps modulo 2^ADDR_W. fill_len up to 2^ADDR_W covers the full RAM.

## Test plan
- Render stream: render_req=1 for 8 cycles at addrs 0..7 with preloaded RAM → render_valid 8 consecutive cycles, data words 0..7 in order, 1-cycle latency.
- Parser write then read under render: render_req toggles 1,0,1,0; parser writes 0x00410007 to addr 5 and then reads it back. Required:
  - both accesses are granted only in render_req=0 cycles;
  - each parser_ack is a single-cycle pulse;
  - the readback equals 0x00410007.
- Fill with preemption: fill_base=0xFFE, fill_len=4, fill_data=0x20, render_req high for 2 cycles mid-fill → writes land at 0xFFE, 0xFFF, 0x000, 0x001. fill_done arrives 6 cycles after fill_busy rises.
- Ordering: fill_len=100 started, then parser read of addr base+99 issued during the fill → parser_ack only after fill_done, rdata=fill_data.
- Edge cases:
  - fill_len=0 → fill_done next cycle, zero RAM writes.
  - fill_start while busy → ignored; original fill completes unchanged.
- Reset mid-fill at write 3 of 10 → fill_busy=0 next cycle, no fill_done, no further writes; a new fill works afterwards.

Source files
------------

// File: rtl/text_ram_scheduler.sv
// text_ram_scheduler: fixed-priority (render > parser > fill) arbiter for the single-port text RAM.
// Ports:
//   render_req/render_addr -> render_valid/render_data : unstalled read stream, 1-cycle latency
//   parser_req/we/addr/wdata -> parser_ack/parser_rdata : held request, one-cycle ack pulse
//   fill_start/base/len/data -> fill_busy/fill_done     : burst writer, paused by render cycles
//   ram_en/we/addr/wdata, ram_rdata                     : RAM macro port, read data one cycle later
module text_ram_scheduler #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              render_req,
   input  logic [ADDR_W-1:0] render_addr,
   output logic              render_valid,
   output logic [DATA_W-1:0] render_data,
   input  logic              parser_req,
   input  logic              parser_we,
   input  logic [ADDR_W-1:0] parser_addr,
   input  logic [DATA_W-1:0] parser_wdata,
   output logic              parser_ack,
   output logic [DATA_W-1:0] parser_rdata,
   input  logic              fill_start,
   input  logic [ADDR_W-1:0] fill_base,
   input  logic [ADDR_W:0]   fill_len,
   input  logic [DATA_W-1:0] fill_data,
   output logic              fill_busy,
   output logic              fill_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;
   logic [0:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] word;
   logic              rd_pend;
   logic              r_g;
   logic              p_g;
   logic              f_g;
   // parser_ack high means the previous grant is still being answered, which
   // enforces the one-cycle gap so a held request is never granted twice
   always_comb begin
      fill_busy    = state == FILL;
      r_g          = render_req;
      p_g          = !render_req && !fill_busy && !parser_ack && parser_req;
      f_g          = !render_req && fill_busy;
      ram_en       = r_g || p_g || f_g;
      ram_we       = (p_g && parser_we) || f_g;
      ram_addr     = r_g ? render_addr : p_g ? parser_addr : f_g ? ptr : '0;
      ram_wdata    = (p_g && parser_we) ? parser_wdata : f_g ? word : '0;
      render_data  = render_valid ? ram_rdata : '0;
      parser_rdata = (parser_ack && rd_pend) ? ram_rdata : '0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         remaining    <= '0;
         word         <= '0;
         rd_pend      <= 1'b0;
         render_valid <= 1'b0;
         parser_ack   <= 1'b0;
         fill_done    <= 1'b0;
      end else begin
         render_valid <= r_g;
         parser_ack   <= p_g;
         rd_pend      <= p_g && !parser_we;
         fill_done    <= 1'b0;
         if (state == IDLE && fill_start) begin
            // a zero-length fill completes immediately without entering FILL
            if (fill_len != '0) begin
               state     <= FILL;
               ptr       <= fill_base;
               remaining <= fill_len;
               word      <= fill_data;
            end else begin
               fill_done <= 1'b1;
            end
         end else if (f_g) begin
            ptr       <= ptr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
               state     <= IDLE;
               fill_done <= 1'b1;
            end
         end
      end
   end
endmodule
